// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: carries decoded operands and control from decode to
// execute, with stall (hold), flush (bubble), valid tag and a saturating bubble counter.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [5:0]        funct_i,
    input  logic [1:0]        aluop_i,
    input  logic              alusrc_i,
    input  logic              regdst_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic              regwrite_i,
    input  logic              memtoreg_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] data1_o,
    output logic [DATA_W-1:0] data2_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [4:0]        rs_o,
    output logic [4:0]        rt_o,
    output logic [4:0]        rd_o,
    output logic [5:0]        funct_o,
    output logic [1:0]        aluop_o,
    output logic              alusrc_o,
    output logic              regdst_o,
    output logic              memread_o,
    output logic              memwrite_o,
    output logic              regwrite_o,
    output logic              memtoreg_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [5:0]        funct;
        logic [1:0]        aluop;
        logic              alusrc;
        logic              regdst;
        logic              memread;
        logic              memwrite;
        logic              regwrite;
        logic              memtoreg;
    } stage_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    stage_t            stage_q, stage_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bubble;

    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
        bubble  = 1'b0;
        if (flush_i) begin
            stage_d = '0;
            bubble  = 1'b1;
        end else if (!stall_i) begin
            stage_d.valid    = valid_i;
            stage_d.pc       = pc_i;
            stage_d.data1    = data1_i;
            stage_d.data2    = data2_i;
            stage_d.imm      = imm_i;
            stage_d.rs       = rs_i;
            stage_d.rt       = rt_i;
            stage_d.rd       = rd_i;
            stage_d.funct    = funct_i;
            stage_d.aluop    = aluop_i;
            stage_d.alusrc   = alusrc_i;
            stage_d.regdst   = regdst_i;
            // Side-effecting controls are squashed for an invalid slot; data still flows.
            stage_d.memread  = memread_i  & valid_i;
            stage_d.memwrite = memwrite_i & valid_i;
            stage_d.regwrite = regwrite_i & valid_i;
            stage_d.memtoreg = memtoreg_i;
            bubble           = ~valid_i;
        end
        if (bubble && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o      = stage_q.valid;
    assign pc_o         = stage_q.pc;
    assign data1_o      = stage_q.data1;
    assign data2_o      = stage_q.data2;
    assign imm_o        = stage_q.imm;
    assign rs_o         = stage_q.rs;
    assign rt_o         = stage_q.rt;
    assign rd_o         = stage_q.rd;
    assign funct_o      = stage_q.funct;
    assign aluop_o      = stage_q.aluop;
    assign alusrc_o     = stage_q.alusrc;
    assign regdst_o     = stage_q.regdst;
    assign memread_o    = stage_q.memread;
    assign memwrite_o   = stage_q.memwrite;
    assign regwrite_o   = stage_q.regwrite;
    assign memtoreg_o   = stage_q.memtoreg;
    assign bubble_cnt_o = cnt_q;

endmodule
